// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded ID fields, forwarding sources, hazard stall and the EX-side outputs.
// The slave modport is the stage itself; the master modport is the surrounding pipeline.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // Instruction in ID
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_dst;
  logic [1:0]        id_alu_op;
  logic [5:0]        id_funct;
  logic              id_alu_src;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              flush;

  // Forwarding / writeback sources from later stages
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_dst;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_dst;
  logic [DATA_W-1:0] memwb_wdata;

  // Stage outputs
  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_dst,
           id_alu_op, id_funct, id_alu_src, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, flush,
           exmem_reg_write, exmem_dst, exmem_result,
           memwb_reg_write, memwb_dst, memwb_wdata,
    output stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_dst,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_dst,
           id_alu_op, id_funct, id_alu_src, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, flush,
           exmem_reg_write, exmem_dst, exmem_result,
           memwb_reg_write, memwb_dst, memwb_wdata,
    input  stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_dst,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS ID/EX pipeline register with ALU-control decode, MEM/WB decode bypass and load-use detection.
// Define ID_EX_FWD_EN to build the EX forwarding muxes; otherwise RAW hazards stall instead.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic     clk,
  input logic     rst_n,
  id_ex_if.slave  bus
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  // ---------------------------------------------------------------- registers
  logic              ex_valid_q,      ex_valid_d;
  logic              ex_reg_write_q,  ex_reg_write_d;
  logic              ex_mem_read_q,   ex_mem_read_d;
  logic              ex_mem_write_q,  ex_mem_write_d;
  logic              ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic              ex_alu_src_q,    ex_alu_src_d;
  logic [3:0]        ex_alu_ctrl_q,   ex_alu_ctrl_d;
  logic [REG_AW-1:0] ex_dst_q,        ex_dst_d;
  logic [DATA_W-1:0] ex_rs_data_q,    ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,    ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,        ex_imm_d;

  // ---------------------------------------------------------------- ALU decode
  logic [3:0] alu_ctrl_dec;

  always_comb begin
    alu_ctrl_dec = CTRL_ADD;
    case (bus.id_alu_op)
      2'b00: alu_ctrl_dec = CTRL_ADD;
      2'b01: alu_ctrl_dec = CTRL_SUB;
      2'b11: alu_ctrl_dec = CTRL_OR;
      default: begin
        case (bus.id_funct)
          6'b100000: alu_ctrl_dec = CTRL_ADD;
          6'b100010: alu_ctrl_dec = CTRL_SUB;
          6'b100100: alu_ctrl_dec = CTRL_AND;
          6'b100101: alu_ctrl_dec = CTRL_OR;
          6'b101010: alu_ctrl_dec = CTRL_SLT;
          6'b100111: alu_ctrl_dec = CTRL_NOR;
          default:   alu_ctrl_dec = CTRL_BAD;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------- ID sources
  // Index 0 is rs, index 1 is rt; rt only matters when the instruction reads it.
  logic [REG_AW-1:0] id_src_idx  [2];
  logic [DATA_W-1:0] id_src_data [2];
  logic [DATA_W-1:0] id_src_cap  [2];
  logic [1:0]        id_src_used;
  logic [1:0]        load_hit;
  logic [1:0]        raw_hit;
  logic              uses_rt;
  logic              stall;

  assign uses_rt        = ~bus.id_alu_src | bus.id_mem_write;
  assign id_src_idx[0]  = bus.id_rs;
  assign id_src_idx[1]  = bus.id_rt;
  assign id_src_data[0] = bus.id_rs_data;
  assign id_src_data[1] = bus.id_rt_data;
  assign id_src_used    = {uses_rt, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_id_src
      // Register file has no internal bypass, so a same-cycle writeback is picked up here.
      assign id_src_cap[gi] = (bus.memwb_reg_write && (bus.memwb_dst != '0) &&
                               (bus.memwb_dst == id_src_idx[gi]))
                              ? bus.memwb_wdata : id_src_data[gi];

      assign load_hit[gi] = id_src_used[gi] && (ex_dst_q != '0) &&
                            (ex_dst_q == id_src_idx[gi]);

`ifdef ID_EX_FWD_EN
      assign raw_hit[gi] = 1'b0;
`else
      assign raw_hit[gi] = id_src_used[gi] &&
                           ((ex_reg_write_q && (ex_dst_q != '0) &&
                             (ex_dst_q == id_src_idx[gi])) ||
                            (bus.exmem_reg_write && (bus.exmem_dst != '0) &&
                             (bus.exmem_dst == id_src_idx[gi])));
`endif
    end
  endgenerate

  assign stall = (bus.id_valid & ex_valid_q & ex_mem_read_q & (|load_hit)) |
                 (bus.id_valid & (|raw_hit));

  // ---------------------------------------------------------------- next state
  always_comb begin
    logic capture;
    capture         = bus.id_valid & ~(bus.flush | stall);
    ex_valid_d      = capture;
    ex_reg_write_d  = capture & bus.id_reg_write;
    ex_mem_read_d   = capture & bus.id_mem_read;
    ex_mem_write_d  = capture & bus.id_mem_write;
    ex_mem_to_reg_d = capture & bus.id_mem_to_reg;
    ex_alu_src_d    = capture & bus.id_alu_src;
    ex_alu_ctrl_d   = capture ? alu_ctrl_dec : CTRL_ADD;
    // Data fields are don't-care in a bubble, so they load unconditionally.
    ex_dst_d        = bus.id_dst;
    ex_rs_data_d    = id_src_cap[0];
    ex_rt_data_d    = id_src_cap[1];
    ex_imm_d        = bus.id_imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_alu_ctrl_q   <= CTRL_ADD;
      ex_dst_q        <= '0;
      ex_rs_data_q    <= '0;
      ex_rt_data_q    <= '0;
      ex_imm_q        <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_alu_ctrl_q   <= ex_alu_ctrl_d;
      ex_dst_q        <= ex_dst_d;
      ex_rs_data_q    <= ex_rs_data_d;
      ex_rt_data_q    <= ex_rt_data_d;
      ex_imm_q        <= ex_imm_d;
    end
  end

  // ---------------------------------------------------------------- EX operands
  logic [DATA_W-1:0] ex_src_data [2];
  logic [DATA_W-1:0] ex_fwd      [2];

  assign ex_src_data[0] = ex_rs_data_q;
  assign ex_src_data[1] = ex_rt_data_q;

`ifdef ID_EX_FWD_EN
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic [REG_AW-1:0] ex_src_idx [2];

  assign ex_rs_d = bus.id_rs;
  assign ex_rt_d = bus.id_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else begin
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
    end
  end

  assign ex_src_idx[0] = ex_rs_q;
  assign ex_src_idx[1] = ex_rt_q;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_ex_fwd
      // EX/MEM is the younger result, so it wins over MEM/WB.
      assign ex_fwd[gi] =
        (bus.exmem_reg_write && (bus.exmem_dst != '0) && (bus.exmem_dst == ex_src_idx[gi]))
          ? bus.exmem_result :
        (bus.memwb_reg_write && (bus.memwb_dst != '0) && (bus.memwb_dst == ex_src_idx[gi]))
          ? bus.memwb_wdata : ex_src_data[gi];
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ex_fwd
      assign ex_fwd[gi] = ex_src_data[gi];
    end
  endgenerate
`endif

  // ---------------------------------------------------------------- outputs
  assign bus.stall         = stall;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_a         = ex_fwd[0];
  assign bus.ex_store_data = ex_fwd[1];
  assign bus.alu_b         = ex_alu_src_q ? ex_imm_q : ex_fwd[1];
  assign bus.alu_ctrl      = ex_alu_ctrl_q;
  assign bus.ex_dst        = ex_dst_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_write  = ex_mem_write_q;
  assign bus.ex_mem_to_reg = ex_mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios plus random traffic checked every cycle
// against an instruction-level model of what EX must hold and present.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_n;

  id_ex_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit verbose = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  typedef struct {
    logic          valid;
    logic [AW-1:0] rs, rt, dst;
    logic [DW-1:0] rs_val, rt_val, imm;
    logic          alu_src, rw, mr, mw, m2r;
    logic [3:0]    ctrl;
    logic          ctrl_is_add;  // bubble/reset: ALU control must read 0010
  } ex_t;

  ex_t m, m_next, m_rst;

  function automatic logic [3:0] ctrl_of(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    if (f == 6'h20) return 4'b0010;
    if (f == 6'h22) return 4'b0110;
    if (f == 6'h24) return 4'b0000;
    if (f == 6'h25) return 4'b0001;
    if (f == 6'h2a) return 4'b0111;
    if (f == 6'h27) return 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [DW-1:0] fwd_of(input logic [AW-1:0] idx, input logic [DW-1:0] v);
`ifdef ID_EX_FWD_EN
    if (idx != 0 && bus.exmem_reg_write && bus.exmem_dst == idx) return bus.exmem_result;
    if (idx != 0 && bus.memwb_reg_write && bus.memwb_dst == idx) return bus.memwb_wdata;
`endif
    if (idx == 5'd31 && v === 'x) return '0;
    return v;
  endfunction

  function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] idx, input logic [DW-1:0] v);
    if (idx != 0 && bus.memwb_reg_write && bus.memwb_dst == idx) return bus.memwb_wdata;
    return v;
  endfunction

  function automatic bit reads(input logic [AW-1:0] d);
    bit urt;
    urt = !bus.id_alu_src || bus.id_mem_write;
    return (d != 0) && ((d == bus.id_rs) || (urt && d == bus.id_rt));
  endfunction

  initial begin
    m_rst = '{valid: 1'b0, rs: '0, rt: '0, dst: '0, rs_val: '0, rt_val: '0, imm: '0,
              alu_src: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0,
              ctrl: 4'b0010, ctrl_is_add: 1'b1};
    m      = m_rst;
    m_next = m_rst;
  end

  always @(posedge clk) m <= m_next;

  // One compare per cycle, mid-cycle, against the model.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_stall", bus.stall, 0);
      chk("rst_ex_valid", bus.ex_valid, 0);
      chk("rst_ctrls", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}, 0);
      chk("rst_ex_dst", bus.ex_dst, 0);
      chk("rst_alu_ctrl", bus.alu_ctrl, 4'b0010);
      m_next = m_rst;
    end else begin
      logic          exp_stall;
      logic [DW-1:0] exp_a, exp_st, exp_b;
      exp_stall = bus.id_valid && m.valid && m.mr && reads(m.dst);
`ifndef ID_EX_FWD_EN
      exp_stall = exp_stall || (bus.id_valid &&
                  ((m.rw && reads(m.dst)) || (bus.exmem_reg_write && reads(bus.exmem_dst))));
`endif
      exp_a  = fwd_of(m.rs, m.rs_val);
      exp_st = fwd_of(m.rt, m.rt_val);
      exp_b  = m.alu_src ? m.imm : exp_st;

      chk("stall", bus.stall, exp_stall);
      chk("ex_valid", bus.ex_valid, m.valid);
      if (m.valid) begin
        chk("alu_a", bus.alu_a, exp_a);
        chk("alu_b", bus.alu_b, exp_b);
        chk("store_data", bus.ex_store_data, exp_st);
        chk("alu_ctrl", bus.alu_ctrl, m.ctrl);
        chk("ex_dst", bus.ex_dst, m.dst);
        chk("ctrls", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg},
            {m.rw, m.mr, m.mw, m.m2r});
      end else begin
        chk("idle_ctrls", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}, 0);
        if (m.ctrl_is_add) chk("bubble_alu_ctrl", bus.alu_ctrl, 4'b0010);
      end
      if (verbose)
        $display("cyc %0d: id_v=%0b rs=%0d rt=%0d flush=%0b stall=%0b | ex_v=%0b rs=%0d rt=%0d a=%h b=%h ctrl=%h",
                 cyc, bus.id_valid, bus.id_rs, bus.id_rt, bus.flush, bus.stall,
                 bus.ex_valid, m.rs, m.rt, bus.alu_a, bus.alu_b, bus.alu_ctrl);

      // What the next edge must load into EX
      if (bus.flush || exp_stall) begin
        m_next = m_rst;
        m_next.rs = bus.id_rs;
        m_next.rt = bus.id_rt;
      end else begin
        m_next.valid       = bus.id_valid;
        m_next.rs          = bus.id_rs;
        m_next.rt          = bus.id_rt;
        m_next.dst         = bus.id_dst;
        m_next.rs_val      = rf_read(bus.id_rs, bus.id_rs_data);
        m_next.rt_val      = rf_read(bus.id_rt, bus.id_rt_data);
        m_next.imm         = bus.id_imm;
        m_next.alu_src     = bus.id_valid && bus.id_alu_src;
        m_next.rw          = bus.id_valid && bus.id_reg_write;
        m_next.mr          = bus.id_valid && bus.id_mem_read;
        m_next.mw          = bus.id_valid && bus.id_mem_write;
        m_next.m2r         = bus.id_valid && bus.id_mem_to_reg;
        m_next.ctrl        = ctrl_of(bus.id_alu_op, bus.id_funct);
        m_next.ctrl_is_add = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_dst = 0; bus.id_alu_op = 0; bus.id_funct = 0;
    bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_mem_to_reg = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_dst = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_dst = 0; bus.memwb_wdata = 0;
  endtask

  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] dst,
                       input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                       input logic [1:0] op, input logic [5:0] f,
                       input logic src, input logic rw, input logic mr, input logic mw, input logic m2r);
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_dst = dst;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.id_alu_op = op; bus.id_funct = f; bus.id_alu_src = src;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_mem_to_reg = m2r;
  endtask

  task automatic issue_lw8();
    issue(5'd1, 5'd8, 5'd8, 32'h100, 0, 32'h4, 2'b00, 6'h0, 1, 1, 1, 0, 1);
  endtask

  logic [5:0] funct_tab [8];

  // ------------------------------------------------------------ main sequence
  initial begin
    funct_tab[0] = 6'h20; funct_tab[1] = 6'h22; funct_tab[2] = 6'h24; funct_tab[3] = 6'h25;
    funct_tab[4] = 6'h2a; funct_tab[5] = 6'h27; funct_tab[6] = 6'h00; funct_tab[7] = 6'h21;
    rst_n = 0;
    idle();
    step();
    chk("reset_alu_ctrl", bus.alu_ctrl, 4'b0010);
    chk("reset_alu_a", bus.alu_a, 0);
    @(posedge clk); #2 rst_n = 1;

    // R-type add, no hazards
    step(); idle();
    issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h99, 2'b10, 6'h20, 0, 1, 0, 0, 0);
    step(); idle(); #1;
    chk("add_ctrl", bus.alu_ctrl, 4'b0010);
    chk("add_a", bus.alu_a, 5);
    chk("add_b", bus.alu_b, 7);
    chk("add_valid", bus.ex_valid, 1);

    // Forwarding priority on a registered rs=3
    issue(5'd3, 5'd4, 5'd5, 32'h33, 32'h0, 32'h0, 2'b00, 6'h0, 0, 0, 0, 0, 0);
    step(); idle();
    bus.exmem_reg_write = 1; bus.exmem_dst = 3; bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1; bus.memwb_dst = 3; bus.memwb_wdata = 32'h22;
    #1;
`ifdef ID_EX_FWD_EN
    chk("fwd_exmem_prio", bus.alu_a, 32'h11);
`else
    chk("nofwd_a_reg", bus.alu_a, 32'h33);
`endif
    bus.exmem_reg_write = 0; #1;
`ifdef ID_EX_FWD_EN
    chk("fwd_memwb", bus.alu_a, 32'h22);
`else
    chk("nofwd_a_reg2", bus.alu_a, 32'h33);
`endif
    issue(5'd0, 5'd4, 5'd6, 32'h44, 32'h0, 32'h0, 2'b00, 6'h0, 0, 0, 0, 0, 0);
    step(); idle();
    bus.exmem_reg_write = 1; bus.exmem_dst = 0; bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1; bus.memwb_dst = 0; bus.memwb_wdata = 32'h22;
    #1 chk("fwd_r0_never", bus.alu_a, 32'h44);

    // Load-use: lw $8 then add reading $8
    step(); idle(); issue_lw8();
    step(); idle();
    issue(5'd8, 5'd2, 5'd9, 32'hDEAD, 32'd7, 32'h0, 2'b10, 6'h20, 0, 1, 0, 0, 0);
    #1 chk("lu_stall", bus.stall, 1);
    step();
    bus.exmem_reg_write = 1; bus.exmem_dst = 8; bus.exmem_result = 32'h0;
    #1;
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_rw", bus.ex_reg_write, 0);
`ifdef ID_EX_FWD_EN
    chk("lu_stall_one_cycle", bus.stall, 0);
    step();
    bus.exmem_reg_write = 0; bus.memwb_reg_write = 1; bus.memwb_dst = 8; bus.memwb_wdata = 32'hABC;
    bus.id_valid = 0;
    #1;
`else
    chk("raw_stall_exmem", bus.stall, 1);
    step();
    bus.exmem_reg_write = 0; bus.memwb_reg_write = 1; bus.memwb_dst = 8; bus.memwb_wdata = 32'hABC;
    #1 chk("raw_stall_clear", bus.stall, 0);
    step(); idle(); #1;
`endif
    chk("lu_alu_a", bus.alu_a, 32'hABC);
    chk("lu_valid", bus.ex_valid, 1);

    // sw with alu_src=1 reads rt -> stall; addi does not
    step(); idle(); issue_lw8();
    step(); idle();
    issue(5'd1, 5'd8, 5'd0, 32'h0, 32'h55, 32'h8, 2'b00, 6'h0, 1, 0, 0, 1, 0);
    #1 chk("sw_rt_stall", bus.stall, 1);
    bus.id_mem_write = 0; bus.id_reg_write = 1; bus.id_dst = 8;
    #1 chk("addi_no_stall", bus.stall, 0);
    bus.id_mem_write = 1; bus.id_reg_write = 0; bus.id_dst = 0; bus.flush = 1;
    #1 chk("flush_stall_stall", bus.stall, 1);
    step(); idle(); #1;
    chk("flush_stall_bubble", bus.ex_valid, 0);

    // Unknown funct
    issue(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 2'b10, 6'h00, 0, 1, 0, 0, 0);
    step(); idle(); #1 chk("bad_funct", bus.alu_ctrl, 4'b1111);

    // Asynchronous reset mid-cycle
    issue_lw8();
    step(); idle();
    issue(5'd8, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 2'b10, 6'h20, 0, 1, 0, 0, 0);
    #1 chk("pre_rst_stall", bus.stall, 1);
    rst_n = 0;
    #1;
    chk("arst_stall", bus.stall, 0);
    chk("arst_valid", bus.ex_valid, 0);
    chk("arst_dst", bus.ex_dst, 0);
    chk("arst_ctrl", bus.alu_ctrl, 4'b0010);
    chk("arst_mr", bus.ex_mem_read, 0);
    chk("arst_a", bus.alu_a, 0);
    chk("arst_b", bus.alu_b, 0);
    @(posedge clk); #2 rst_n = 1;

    // Random traffic with small register indices so hazards and forwards are frequent
    verbose = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.id_valid        = ($urandom_range(0, 7) != 0);
      bus.id_rs           = AW'($urandom_range(0, 3));
      bus.id_rt           = AW'($urandom_range(0, 3));
      bus.id_dst          = AW'($urandom_range(0, 3));
      bus.id_rs_data      = $urandom;
      bus.id_rt_data      = $urandom;
      bus.id_imm          = $urandom;
      bus.id_alu_op       = 2'($urandom_range(0, 3));
      bus.id_funct        = funct_tab[$urandom_range(0, 7)];
      bus.id_alu_src      = 1'($urandom_range(0, 1));
      bus.id_reg_write    = 1'($urandom_range(0, 1));
      bus.id_mem_read     = ($urandom_range(0, 2) == 0);
      bus.id_mem_write    = ($urandom_range(0, 3) == 0);
      bus.id_mem_to_reg   = 1'($urandom_range(0, 1));
      bus.flush           = ($urandom_range(0, 7) == 0);
      bus.exmem_reg_write = 1'($urandom_range(0, 1));
      bus.exmem_dst       = AW'($urandom_range(0, 3));
      bus.exmem_result    = $urandom;
      bus.memwb_reg_write = 1'($urandom_range(0, 1));
      bus.memwb_dst       = AW'($urandom_range(0, 3));
      bus.memwb_wdata     = $urandom;
    end
    step(); idle();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
